// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller.
// Run phases, in the order a normal run visits them.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RUN,
    DONE
  } run_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_controller_if.sv
// Run-control bundle between the bench/debug side and the controller.
// The master side starts and aborts runs; the slave side owns the status.
interface run_controller_if #(
  parameter int N_CORES = 1,
  parameter int CNT_W   = 32
);

  logic               start;
  logic               abort;
  logic [N_CORES-1:0] halt;
  logic [N_CORES-1:0] core_rst;
  logic               busy;
  logic               done;
  logic               timed_out;
  logic [N_CORES-1:0] halted_mask;
  logic [CNT_W-1:0]   cycle_count;

  modport master (
    output start,
    output abort,
    output halt,
    input  core_rst,
    input  busy,
    input  done,
    input  timed_out,
    input  halted_mask,
    input  cycle_count
  );

  modport slave (
    input  start,
    input  abort,
    input  halt,
    output core_rst,
    output busy,
    output done,
    output timed_out,
    output halted_mask,
    output cycle_count
  );

endinterface

// File: rtl/core_release_seq.sv
// Staggered release mask: core 0 on go, core k STAGGER*k edges later.
// Bits only ever rise until clr drops them all at once.
module core_release_seq
  import run_ctrl_pkg::*;
#(
  parameter int N_CORES = 1,
  parameter int STAGGER = 0
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               clr,
  input  logic               go,
  output logic [N_CORES-1:0] rel
);

  localparam int SW = cnt_width(STAGGER);
  localparam logic [SW-1:0] LAST =
    SW'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [N_CORES-1:0] ALL = '1;
  localparam logic [N_CORES-1:0] ONE = N_CORES'(1);

  logic [SW-1:0] cnt;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rel <= '0;
      cnt <= '0;
    end else if (clr) begin
      rel <= '0;
      cnt <= '0;
    end else if (go) begin
      rel <= (STAGGER == 0) ? ALL : ONE;
      cnt <= '0;
    end else if (rel != '0 && rel != ALL) begin
      if (cnt == LAST) begin
        rel <= (rel << 1) | ONE;
        cnt <= '0;
      end else begin
        cnt <= cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/run_controller.sv
// Reset-and-run sequencer for one or more cores: hold, staggered
// release, cycle budget, halt collection.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int N_CORES    = 1,
  parameter int RST_CYCLES = 1,
  parameter int STAGGER    = 0,
  parameter int MAX_CYCLES = 1000000,
  parameter int CNT_W      = 32
) (
  input  logic          clock,
  input  logic          rst,
  run_controller_if.slave bus
);

  localparam int HW = cnt_width(RST_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

  run_state_t         state, state_n;
  logic [HW-1:0]      hold_q, hold_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [N_CORES-1:0] mask_q, mask_n;
  logic               to_q, to_n;
  logic               busy_q, done_q;
  logic [N_CORES-1:0] rel;
  logic [CNT_W-1:0]   run_cnt;
  logic [N_CORES-1:0] run_mask;
  logic               go, clr;

  assign run_cnt  = cnt_q + CNT_W'(1);
  assign run_mask = mask_q | (bus.halt & rel);

  always_comb begin
    state_n = state;
    hold_n  = hold_q;
    cnt_n   = cnt_q;
    mask_n  = mask_q;
    to_n    = to_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = HOLD;
          hold_n  = '0;
          cnt_n   = '0;
          mask_n  = '0;
          to_n    = 1'b0;
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_n = RUN;
        end else begin
          hold_n = hold_q + HW'(1);
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else begin
          cnt_n  = run_cnt;
          mask_n = run_mask;
          // completion outranks a budget hit on the same edge
          if (&run_mask) begin
            state_n = DONE;
          end else if (run_cnt == CNT_MAX) begin
            state_n = DONE;
            to_n    = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (bus.start) begin
          state_n = HOLD;
          hold_n  = '0;
          cnt_n   = '0;
          mask_n  = '0;
          to_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign go  = (state == HOLD) && (state_n == RUN);
  assign clr = (state_n != RUN);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hold_q <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
      to_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      hold_q <= hold_n;
      cnt_q  <= cnt_n;
      mask_q <= mask_n;
      to_q   <= to_n;
      busy_q <= (state_n == HOLD) || (state_n == RUN);
      done_q <= (state_n == DONE);
    end
  end

  core_release_seq #(
    .N_CORES (N_CORES),
    .STAGGER (STAGGER)
  ) u_rel (
    .clock (clock),
    .rst   (rst),
    .clr   (clr),
    .go    (go),
    .rel   (rel)
  );

  assign bus.core_rst    = ~rel;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timed_out   = to_q;
  assign bus.halted_mask = mask_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: vector table on the default
// build plus hand sequences on stagger, timeout and reset variants.
module tb_run_controller;

  logic clock;
  logic rst;

  int n_cmp;
  int n_err;

  run_controller_if #(.N_CORES(1), .CNT_W(32)) ia ();
  run_controller_if #(.N_CORES(3), .CNT_W(32)) ib ();
  run_controller_if #(.N_CORES(1), .CNT_W(32)) ic ();
  run_controller_if #(.N_CORES(1), .CNT_W(32)) id ();

  run_controller ua (
    .clock (clock),
    .rst   (rst),
    .bus   (ia)
  );

  run_controller #(
    .N_CORES    (3),
    .RST_CYCLES (2),
    .STAGGER    (4),
    .MAX_CYCLES (1000)
  ) ub (
    .clock (clock),
    .rst   (rst),
    .bus   (ib)
  );

  run_controller #(
    .MAX_CYCLES (20)
  ) uc (
    .clock (clock),
    .rst   (rst),
    .bus   (ic)
  );

  run_controller #(
    .MAX_CYCLES (5)
  ) ud (
    .clock (clock),
    .rst   (rst),
    .bus   (id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        start;
    logic        abort;
    logic        halt;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        to;
    logic        mask;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv [20];

  function automatic vec_t mk(
    input logic s, input logic a, input logic h,
    input logic r, input logic b, input logic d,
    input logic t, input logic m, input int c
  );
    vec_t v;
    v.start = s; v.abort = a; v.halt = h;
    v.core_rst = r; v.busy = b; v.done = d;
    v.to = t; v.mask = m; v.cnt = 32'(c);
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ia.start = 0; ia.abort = 0; ia.halt = '0;
    ib.start = 0; ib.abort = 0; ib.halt = '0;
    ic.start = 0; ic.abort = 0; ic.halt = '0;
    id.start = 0; id.abort = 0; id.halt = '0;

    //        s a h   r b d t m cnt
    tv[0]  = mk(1,0,0, 1,1,0,0,0, 0);
    tv[1]  = mk(0,0,0, 0,1,0,0,0, 0);
    for (int i = 2; i <= 10; i++)
      tv[i] = mk(0,0,0, 0,1,0,0,0, i - 1);
    tv[11] = mk(0,0,1, 1,0,1,0,1, 10);
    tv[12] = mk(1,0,0, 1,1,0,0,0, 0);
    tv[13] = mk(0,0,0, 0,1,0,0,0, 0);
    tv[14] = mk(1,0,0, 0,1,0,0,0, 1);
    tv[15] = mk(0,0,0, 0,1,0,0,0, 2);
    tv[16] = mk(0,1,0, 1,0,0,0,0, 2);
    tv[17] = mk(1,0,0, 1,1,0,0,0, 0);
    tv[18] = mk(0,0,0, 0,1,0,0,0, 0);
    tv[19] = mk(0,0,1, 1,0,1,0,1, 1);

    #12;
    chk("rst core_rst", 64'(ia.core_rst), 64'(1'b1));
    chk("rst busy", 64'(ia.busy), 64'(0));
    chk("rst done", 64'(ia.done), 64'(0));
    chk("rst cnt", 64'(ia.cycle_count), 64'(0));
    chk("rst b core_rst", 64'(ib.core_rst), 64'(3'b111));
    chk("rst b mask", 64'(ib.halted_mask), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      ia.start = tv[i].start;
      ia.abort = tv[i].abort;
      ia.halt  = tv[i].halt;
      step(1);
      chk($sformatf("v%0d core_rst", i),
          64'(ia.core_rst), 64'(tv[i].core_rst));
      chk($sformatf("v%0d busy", i),
          64'(ia.busy), 64'(tv[i].busy));
      chk($sformatf("v%0d done", i),
          64'(ia.done), 64'(tv[i].done));
      chk($sformatf("v%0d timed_out", i),
          64'(ia.timed_out), 64'(tv[i].to));
      chk($sformatf("v%0d mask", i),
          64'(ia.halted_mask), 64'(tv[i].mask));
      chk($sformatf("v%0d cnt", i),
          64'(ia.cycle_count), 64'(tv[i].cnt));
    end
    ia.start = 0; ia.abort = 0; ia.halt = '0;

    // async reset in the middle of HOLD
    ia.start = 1;
    step(1);
    ia.start = 0;
    chk("hold busy", 64'(ia.busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst hold busy", 64'(ia.busy), 64'(0));
    chk("rst hold core_rst", 64'(ia.core_rst), 64'(1));
    chk("rst hold done", 64'(ia.done), 64'(0));
    rst = 1'b0;
    ia.start = 1;
    step(1);
    chk("first start busy", 64'(ia.busy), 64'(1));
    ia.start = 0;
    step(3);
    chk("run cnt", 64'(ia.cycle_count), 64'(2));
    chk("run core_rst", 64'(ia.core_rst), 64'(0));
    #2 rst = 1'b1;
    #1;
    chk("rst run cnt", 64'(ia.cycle_count), 64'(0));
    chk("rst run core_rst", 64'(ia.core_rst), 64'(1));
    chk("rst run busy", 64'(ia.busy), 64'(0));
    rst = 1'b0;

    // staggered release with halt held high from start
    ib.halt = 3'b111;
    ib.start = 1;
    step(1);
    ib.start = 0;
    chk("b E0 core_rst", 64'(ib.core_rst), 64'(3'b111));
    chk("b E0 busy", 64'(ib.busy), 64'(1));
    step(1);
    chk("b E1 core_rst", 64'(ib.core_rst), 64'(3'b111));
    step(1);
    chk("b E2 core_rst", 64'(ib.core_rst), 64'(3'b110));
    chk("b E2 mask", 64'(ib.halted_mask), 64'(3'b000));
    step(1);
    chk("b E3 mask", 64'(ib.halted_mask), 64'(3'b001));
    step(3);
    chk("b E6 core_rst", 64'(ib.core_rst), 64'(3'b100));
    chk("b E6 mask", 64'(ib.halted_mask), 64'(3'b001));
    step(1);
    chk("b E7 mask", 64'(ib.halted_mask), 64'(3'b011));
    step(3);
    chk("b E10 core_rst", 64'(ib.core_rst), 64'(3'b000));
    chk("b E10 mask", 64'(ib.halted_mask), 64'(3'b011));
    chk("b E10 done", 64'(ib.done), 64'(0));
    step(1);
    chk("b E11 done", 64'(ib.done), 64'(1));
    chk("b E11 mask", 64'(ib.halted_mask), 64'(3'b111));
    chk("b E11 cnt", 64'(ib.cycle_count), 64'(9));
    chk("b E11 core_rst", 64'(ib.core_rst), 64'(3'b111));
    chk("b E11 timed_out", 64'(ib.timed_out), 64'(0));
    ib.halt = '0;

    // budget of 20 with no halt
    ic.start = 1;
    step(1);
    ic.start = 0;
    for (int i = 0; i < 40 && !ic.done; i++) step(1);
    chk("c done", 64'(ic.done), 64'(1));
    chk("c timed_out", 64'(ic.timed_out), 64'(1));
    chk("c cnt", 64'(ic.cycle_count), 64'(20));
    chk("c core_rst", 64'(ic.core_rst), 64'(1));
    chk("c busy", 64'(ic.busy), 64'(0));

    // halt landing exactly on the budget edge
    id.start = 1;
    step(1);
    id.start = 0;
    step(5);
    chk("d cnt4", 64'(id.cycle_count), 64'(4));
    chk("d done early", 64'(id.done), 64'(0));
    id.halt = 1'b1;
    step(1);
    id.halt = 1'b0;
    chk("d tie done", 64'(id.done), 64'(1));
    chk("d tie timed_out", 64'(id.timed_out), 64'(0));
    chk("d tie cnt", 64'(id.cycle_count), 64'(5));
    chk("d tie mask", 64'(id.halted_mask), 64'(1));
    id.start = 1;
    step(1);
    id.start = 0;
    step(6);
    chk("d to done", 64'(id.done), 64'(1));
    chk("d to timed_out", 64'(id.timed_out), 64'(1));
    chk("d to cnt", 64'(id.cycle_count), 64'(5));
    step(2);
    chk("d frozen cnt", 64'(id.cycle_count), 64'(5));
    id.start = 1;
    step(1);
    id.start = 0;
    chk("d restart timed_out", 64'(id.timed_out), 64'(0));
    chk("d restart cnt", 64'(id.cycle_count), 64'(0));
    id.abort = 1;
    step(1);
    id.abort = 0;
    chk("d abort busy", 64'(id.busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
